// File: rtl/load_store_ctrl.sv
// load_store_ctrl: sequences one load/store from MEM onto a req/ack data-memory port.
// Latency: fault 1 cycle; ack at ACCESS cycle k gives done at k+1 (min 2); timeout TIMEOUT+1.
// Backpressure: busy stalls the pipeline until done; start is ignored outside IDLE.
// Ports: clk/reset (sync, active-high); start/is_store/funct3/addr/wdata request;
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_ack/mem_rdata memory handshake;
//   busy/done/rdata_out/misaligned/timeout_err pipeline status and result.
module load_store_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        misaligned,
  output logic        timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // The counter is compared one short of TIMEOUT so the abort lands on the
  // same edge that would make it reach TIMEOUT.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wait_cnt;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;

  logic            fault;
  logic            expire;
  logic [3:0]      be_new;
  logic [31:0]     wdata_new;
  logic [31:0]     rd_shift;
  logic [31:0]     rd_ext;

  // Request checks use the live inputs since they are only acted on in IDLE.
  always_comb begin
    fault = 1'b0;
    if (funct3 == 3'b011 || funct3[2:1] == 2'b11) fault = 1'b1;
    if (is_store && funct3[2])                    fault = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0])          fault = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) fault = 1'b1;
  end

  // Lane enables and replicated store data; replication lets the memory pick
  // the active lanes without any shifting on its side.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_new    = 4'b0001 << addr[1:0];
        wdata_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new    = 4'b0011 << addr[1:0];
        wdata_new = {2{wdata[15:0]}};
      end
      default: begin
        be_new    = 4'b1111;
        wdata_new = wdata;
      end
    endcase
  end

  // Load alignment and extension from the latched request.
  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
      3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  // An ack in the last allowed cycle wins over the timeout.
  assign expire = (wait_cnt == LAST_WAIT) && !mem_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = fault ? DONE : ACCESS;
      ACCESS:  if (mem_ack || expire) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 32'd0;
      mem_be      <= 4'd0;
      mem_wdata   <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata_out   <= 32'd0;
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      busy        <= (state_d != IDLE);
      done        <= (state_d == DONE);
      misaligned  <= 1'b0;
      timeout_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            funct3_q   <= funct3;
            off_q      <= addr[1:0];
            wait_cnt   <= '0;
            if (fault) begin
              misaligned <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_new;
              mem_wdata <= wdata_new;
            end
          end
        end
        ACCESS: begin
          if (mem_ack || expire) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
            if (mem_ack) begin
              if (!is_store_q) rdata_out <= rd_ext;
            end else begin
              timeout_err <= 1'b1;
              rdata_out   <= 32'd0;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb_load_store_ctrl: randomized and directed load/store traffic against a reference model.
// Driver pushes expected outcomes; an independent monitor checks mem_* and done results.
// Memory ack delay is chosen per transaction, including delays past the timeout.
module tb_load_store_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata_out;
  logic        misaligned;
  logic        timeout_err;

  load_store_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .rdata_out(rdata_out),
    .misaligned(misaligned), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        fault;
    logic        tmo;
    logic        we;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [3:0]  be;
    int          req_cycles;
    int          latency;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          req_cnt = 0;
  logic        no_sb = 1'b1;
  logic [31:0] hold = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents with the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && !no_sb) begin
      if (mem_req) begin
        if (sb.size() == 0) begin
          chk("req_unexpected", 32'd1, 32'd0);
        end else begin
          chk("mem_addr", mem_addr, sb[0].maddr);
          chk("mem_be", {28'd0, mem_be}, {28'd0, sb[0].be});
          chk("mem_we", {31'd0, mem_we}, {31'd0, sb[0].we});
          if (sb[0].we) chk("mem_wdata", mem_wdata, sb[0].mwdata);
          req_cnt++;
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("misaligned", {31'd0, misaligned}, {31'd0, e.fault});
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.tmo});
          chk("rdata_out", rdata_out, e.rdata);
          chk("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.latency));
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
        req_cnt = 0;
      end else if (!busy) begin
        chk("flags_idle", {30'd0, misaligned, timeout_err}, 32'd0);
      end
    end
  end

  // Issues one request in the current (IDLE) cycle and returns in the first IDLE cycle after it.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int d);
    exp_t       e;
    int         size;
    int         off;
    int         i;
    logic       legal;
    logic [63:0] raw;
    logic [63:0] mask;
    logic [63:0] val;

    legal  = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size   = 1 << f3[1:0];
    off    = int'(a[1:0]);
    e.fault = !legal || (st && f3[2]) || ((off % size) != 0);
    e.tmo   = !e.fault && (d >= TIMEOUT);
    e.we    = st;
    e.maddr = a & 32'hFFFF_FFFC;
    e.be    = 4'(((1 << size) - 1) << off);
    for (int b = 0; b < 4; b++) e.mwdata[8*b +: 8] = 8'(wd >> (8 * (b % size)));
    raw  = {32'd0, rd} >> (8 * off);
    mask = (64'd1 << (8 * size)) - 64'd1;
    val  = raw & mask;
    if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~mask;
    if (e.fault)    e.rdata = hold;
    else if (e.tmo) e.rdata = 32'd0;
    else if (!st)   e.rdata = val[31:0];
    else            e.rdata = hold;
    hold = e.rdata;
    e.req_cycles = e.fault ? 0 : (e.tmo ? TIMEOUT : d + 1);
    e.latency    = e.fault ? 1 : (e.tmo ? TIMEOUT + 1 : d + 2);
    e.start_cyc  = cyc;
    sb.push_back(e);

    start     = 1'b1;
    is_store  = st;
    funct3    = f3;
    addr      = a;
    wdata     = wd;
    mem_ack   = 1'($urandom % 2);   // ack while IDLE must be ignored
    mem_rdata = $urandom;

    i = 0;
    do begin
      @(posedge clk); #1;
      mem_ack   = e.fault ? 1'($urandom % 2) : (i == d);
      mem_rdata = (i == d) ? rd : $urandom;
      if (busy) begin
        start    = 1'($urandom % 2);  // start outside IDLE must be ignored
        is_store = 1'($urandom % 2);
        funct3   = 3'($urandom);
        addr     = $urandom;
        wdata    = $urandom;
      end else begin
        start = 1'b0;
      end
      i++;
    end while (busy && i < 20);
    if (busy) chk("op_bound", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start   = 1'b0;
      mem_ack = 1'b0;
    end
  endtask

  initial begin
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          d;

    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
    wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_be_wd", {28'd0, mem_be} | mem_wdata, 32'd0);
    chk("rst_flags", {30'd0, misaligned, timeout_err}, 32'd0);
    reset = 1'b0;
    no_sb = 1'b0;
    idle(1);

    // Directed cases.
    do_op(1'b0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 0);
    chk("lb_sext", rdata_out, 32'hFFFF_FF80);
    do_op(1'b0, 3'b101, 32'h0000_2002, 32'd0, 32'hBEEF_0001, 1);
    chk("lhu_zext", rdata_out, 32'h0000_BEEF);
    do_op(1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'hBEEF_0001, 2);
    chk("lh_sext", rdata_out, 32'hFFFF_BEEF);
    do_op(1'b1, 3'b000, 32'h0000_0011, 32'h1234_56AB, 32'd0, 3);
    chk("sb_keeps_rdata", rdata_out, 32'hFFFF_BEEF);
    do_op(1'b0, 3'b010, 32'h0000_0006, 32'd0, 32'd0, 0);
    do_op(1'b1, 3'b001, 32'h0000_0003, 32'h5555_5555, 32'd0, 0);
    do_op(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, 5);
    chk("timeout_zero", rdata_out, 32'd0);
    do_op(1'b0, 3'b010, 32'h0000_0100, 32'd0, 32'hCAFE_F00D, TIMEOUT - 1);
    chk("ack_beats_timeout", rdata_out, 32'hCAFE_F00D);
    idle(2);

    // Reset in the middle of ACCESS.
    no_sb = 1'b1;
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h40; mem_ack = 1'b0;
    @(posedge clk); #1; start = 1'b0;
    chk("rstmid_req_on", {31'd0, mem_req}, 32'd1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("rstmid_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1; mem_ack = 1'b0;
    chk("late_ack_done", {31'd0, done}, 32'd0);
    chk("late_ack_busy", {31'd0, busy}, 32'd0);
    chk("late_ack_rdata", rdata_out, 32'd0);
    hold  = 32'd0;
    req_cnt = 0;
    no_sb = 1'b0;
    do_op(1'b0, 3'b100, 32'h0000_0041, 32'd0, 32'h0000_9A00, 1);
    chk("after_rst_lbu", rdata_out, 32'h0000_009A);

    // Randomized traffic, with back-to-back starts when the gap is zero.
    for (int n = 0; n < 300; n++) begin
      st = 1'($urandom % 2);
      f3 = 3'($urandom);
      a  = $urandom;
      if ($urandom % 3 != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      d = $urandom_range(0, TIMEOUT + 1);
      do_op(st, f3, a, $urandom, $urandom, d);
      idle($urandom_range(0, 2));
    end

    for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
    if (sb.size() != 0) chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
